// File: rtl/ir_chk_pkg.sv
// Shared types and helpers for the multi-channel IR pulse checker.
package ir_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic longint unsigned cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/ir_pulse_qual.sv
// Per-channel input path: 2-flop synchronizer, polarity fold, run-length qualifier.
// Emits a 1-cycle pulse on the cycle an asserted run reaches MIN_PW.
module ir_pulse_qual #(
    parameter int MIN_PW = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic pol_i,
    input  logic raw_i,
    output logic pulse_o
);

    localparam int RW = $clog2(MIN_PW + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(MIN_PW - 1);
    localparam logic [RW-1:0] RUN_SAT  = RW'(MIN_PW);

    logic          sync1_q, sync2_q;
    logic [RW-1:0] run_q, run_d;
    logic          act;

    assign act     = sync2_q ^ pol_i;
    assign pulse_o = act && (run_q == RUN_LAST);

    // Run length saturates at MIN_PW so a held-asserted input counts only once.
    always_comb begin
        run_d = '0;
        if (!clr_i && act) begin
            run_d = (run_q == RUN_SAT) ? RUN_SAT : run_q + RW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            run_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/ir_pulse_checker.sv
// Windowed multi-channel pulse counter with expected-count compare and timeout.
// Results are registered on the RUN->DONE edge and held until the next accepted start.
module ir_pulse_checker
    import ir_chk_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int TMO_W  = 26,
    parameter int MIN_PW = 4,
    parameter int EXACT  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [TMO_W-1:0]        timeout_cyc,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_pol,
    input  logic [NUM_CH*CNT_W-1:0] exp_cnt,
    input  logic [NUM_CH-1:0]       ch_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    tmo,
    output logic [NUM_CH-1:0]       err_mask,
    output logic [NUM_CH*CNT_W-1:0] cnt_out
);

    localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [TMO_W-1:0] TMAX = '1;

    state_t                        state_q, state_d;
    logic [NUM_CH-1:0]             en_q, pol_q;
    logic [NUM_CH-1:0][CNT_W-1:0]  exp_q;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]              lim_q, timer_q;
    logic [NUM_CH-1:0]             err_q, err_calc;
    logic                          pass_q, tmo_q, done_q;
    logic [NUM_CH-1:0]             qual_pulse;
    logic                          accept, tmo_hit, finish, is_arm;

    assign is_arm  = (state_q == ARM);
    assign accept  = start && (state_q == IDLE || state_q == DONE);
    assign tmo_hit = (timer_q == lim_q - TMO_W'(1));
    assign finish  = (state_q == RUN) && (stop || tmo_hit);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ir_pulse_qual #(.MIN_PW(MIN_PW)) u_qual (
            .clk_i   (clk),
            .rst_i   (rst),
            .clr_i   (is_arm),
            .pol_i   (pol_q[g]),
            .raw_i   (ch_in[g]),
            .pulse_o (qual_pulse[g])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ARM;
            ARM:     state_d = RUN;
            RUN:     if (stop || tmo_hit) state_d = DONE;
            DONE:    if (start) state_d = ARM;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept) begin
                cnt_d[i] = '0;
            end else if (state_q == RUN && en_q[i] && qual_pulse[i] && cnt_q[i] != CMAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Compare uses cnt_d so a pulse qualifying on the closing cycle is included.
    always_comb begin
        err_calc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (EXACT != 0) err_calc[i] = en_q[i] && (cnt_d[i] != exp_q[i]);
            else            err_calc[i] = en_q[i] && (cnt_d[i] <  exp_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= '0;
            pol_q   <= '0;
            exp_q   <= '0;
            lim_q   <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= finish;
            if (accept) begin
                en_q    <= ch_en;
                pol_q   <= ch_pol;
                exp_q   <= exp_cnt;
                lim_q   <= (timeout_cyc == '0) ? TMAX : timeout_cyc;
                timer_q <= '0;
                err_q   <= '0;
                pass_q  <= 1'b0;
                tmo_q   <= 1'b0;
            end else if (state_q == RUN) begin
                timer_q <= timer_q + TMO_W'(1);
            end
            if (finish) begin
                err_q  <= err_calc;
                tmo_q  <= tmo_hit && !stop;
                pass_q <= !(tmo_hit && !stop) && (err_calc == '0);
            end
        end
    end

    assign busy     = (state_q == ARM) || (state_q == RUN);
    assign done     = done_q;
    assign pass     = pass_q;
    assign tmo      = tmo_q;
    assign err_mask = err_q;
    assign cnt_out  = cnt_q;

endmodule

// File: tb/tb_ir_pulse_checker.sv
// Directed bench: three instances (default, EXACT=0, CNT_W=4) share control and channel inputs.
module tb_ir_pulse_checker;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [25:0] timeout_cyc;
    logic [3:0]  ch_en, ch_pol, ch_in;
    logic [31:0] exp_a;
    logic [15:0] exp_c;

    logic        busy_a, done_a, pass_a, tmo_a;
    logic [3:0]  err_a;
    logic [31:0] cnt_a;
    logic        busy_b, done_b, pass_b, tmo_b;
    logic [3:0]  err_b;
    logic [31:0] cnt_b;
    logic        busy_c, done_c, pass_c, tmo_c;
    logic [3:0]  err_c;
    logic [15:0] cnt_c;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ir_pulse_checker #(.NUM_CH(4), .CNT_W(8), .TMO_W(26), .MIN_PW(4), .EXACT(1)) u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .timeout_cyc(timeout_cyc),
        .ch_en(ch_en), .ch_pol(ch_pol), .exp_cnt(exp_a), .ch_in(ch_in),
        .busy(busy_a), .done(done_a), .pass(pass_a), .tmo(tmo_a), .err_mask(err_a), .cnt_out(cnt_a));

    ir_pulse_checker #(.NUM_CH(4), .CNT_W(8), .TMO_W(26), .MIN_PW(4), .EXACT(0)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .timeout_cyc(timeout_cyc),
        .ch_en(ch_en), .ch_pol(ch_pol), .exp_cnt(exp_a), .ch_in(ch_in),
        .busy(busy_b), .done(done_b), .pass(pass_b), .tmo(tmo_b), .err_mask(err_b), .cnt_out(cnt_b));

    ir_pulse_checker #(.NUM_CH(4), .CNT_W(4), .TMO_W(26), .MIN_PW(4), .EXACT(1)) u_c (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .timeout_cyc(timeout_cyc),
        .ch_en(ch_en), .ch_pol(ch_pol), .exp_cnt(exp_c), .ch_in(ch_in),
        .busy(busy_c), .done(done_c), .pass(pass_c), .tmo(tmo_c), .err_mask(err_c), .cnt_out(cnt_c));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Active-low pulse on the channels in mask m (idle level is high).
    task automatic pulse(input logic [3:0] m, input int w, input int gap);
        ch_in = 4'hF & ~m;
        tick(w);
        ch_in = 4'hF;
        tick(gap);
    endtask

    task automatic wait_done(input int max, output bit seen);
        int i;
        seen = 1'b0;
        i = 0;
        while (i < max && !seen) begin
            if (done_a === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; timeout_cyc = '0;
        ch_en = 4'h0; ch_pol = 4'hF; ch_in = 4'hF; exp_a = '0; exp_c = '0;
        tick(3);
        n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
        n_total++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else n_pass++;
        n_total++; if (pass_a !== 1'b0) $display("FAIL reset_pass: got %b want 0", pass_a); else n_pass++;
        n_total++; if (tmo_a !== 1'b0) $display("FAIL reset_tmo: got %b want 0", tmo_a); else n_pass++;
        n_total++; if (err_a !== 4'h0) $display("FAIL reset_err: got %h want 0", err_a); else n_pass++;
        n_total++; if (cnt_a !== 32'h0) $display("FAIL reset_cnt: got %h want 0", cnt_a); else n_pass++;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        bit seen;
        ch_en = 4'b0001; ch_pol = 4'hF; exp_a = 32'd2; exp_c = 16'd2; timeout_cyc = '0;
        do_start();
        tick(2);
        ch_in = 4'hE;
        tick(5);
        n_total++; if (cnt_a[7:0] !== 8'd0) $display("FAIL lat_before: got %0d want 0", cnt_a[7:0]); else n_pass++;
        tick(1);
        n_total++; if (cnt_a[7:0] !== 8'd1) $display("FAIL lat_at: got %0d want 1", cnt_a[7:0]); else n_pass++;
        tick(4);
        ch_in = 4'hF;
        tick(10);
        pulse(4'b0001, 10, 10);
        n_total++; if (busy_a !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy_a); else n_pass++;
        do_stop();
        wait_done(20, seen);
        n_total++; if (!seen) $display("FAIL basic_done: got none want done pulse"); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL basic_pass: got %b want 1", pass_a); else n_pass++;
        n_total++; if (cnt_a[7:0] !== 8'd2) $display("FAIL basic_cnt: got %0d want 2", cnt_a[7:0]); else n_pass++;
        n_total++; if (tmo_a !== 1'b0) $display("FAIL basic_tmo: got %b want 0", tmo_a); else n_pass++;
        tick(3);
        n_total++; if (done_a !== 1'b0) $display("FAIL basic_done_1cyc: got %b want 0", done_a); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL basic_pass_held: got %b want 1", pass_a); else n_pass++;
        n_total++; if (busy_a !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy_a); else n_pass++;
    endtask

    task automatic test_glitch();
        bit seen;
        ch_en = 4'b0001; exp_a = 32'd4; exp_c = 16'd4;
        do_start();
        tick(2);
        pulse(4'b0001, 8, 6);
        pulse(4'b0001, 2, 6);
        pulse(4'b0001, 8, 6);
        pulse(4'b0001, 3, 6);
        pulse(4'b0001, 8, 6);
        pulse(4'b0001, 4, 8);
        do_stop();
        wait_done(20, seen);
        n_total++; if (!seen) $display("FAIL glitch_done: got none want done pulse"); else n_pass++;
        n_total++; if (cnt_a[7:0] !== 8'd4) $display("FAIL glitch_cnt: got %0d want 4", cnt_a[7:0]); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL glitch_pass: got %b want 1", pass_a); else n_pass++;
        n_total++; if (err_a !== 4'h0) $display("FAIL glitch_err: got %h want 0", err_a); else n_pass++;
    endtask

    task automatic test_exact();
        bit seen;
        ch_en = 4'b0010; exp_a = 32'h0000_0100; exp_c = 16'h0010;
        do_start();
        tick(2);
        repeat (3) pulse(4'b0010, 6, 6);
        do_stop();
        wait_done(20, seen);
        n_total++; if (!seen) $display("FAIL exact_done: got none want done pulse"); else n_pass++;
        n_total++; if (cnt_a[15:8] !== 8'd3) $display("FAIL exact_cnt1: got %0d want 3", cnt_a[15:8]); else n_pass++;
        n_total++; if (err_a !== 4'b0010) $display("FAIL exact_err: got %b want 0010", err_a); else n_pass++;
        n_total++; if (pass_a !== 1'b0) $display("FAIL exact_pass: got %b want 0", pass_a); else n_pass++;
        n_total++; if (pass_b !== 1'b1) $display("FAIL atleast_pass: got %b want 1", pass_b); else n_pass++;
        n_total++; if (err_b !== 4'h0) $display("FAIL atleast_err: got %b want 0000", err_b); else n_pass++;
    endtask

    task automatic test_timeout();
        bit seen;
        int busy_cnt;
        int i;
        ch_en = 4'b0001; exp_a = 32'd0; exp_c = 16'd0; timeout_cyc = 26'd1000;
        do_start();
        n_total++; if (pass_b !== 1'b0) $display("FAIL arm_clr_pass: got %b want 0", pass_b); else n_pass++;
        n_total++; if (err_a !== 4'h0) $display("FAIL arm_clr_err: got %b want 0", err_a); else n_pass++;
        busy_cnt = 0; seen = 1'b0; i = 0;
        while (i < 1200 && !seen) begin
            if (done_a === 1'b1) seen = 1'b1;
            else begin
                if (busy_a === 1'b1) busy_cnt++;
                @(negedge clk);
                i++;
            end
        end
        n_total++; if (!seen) $display("FAIL tmo_done: got none want done pulse"); else n_pass++;
        n_total++; if (busy_cnt !== 1001) $display("FAIL tmo_len: got %0d busy cycles want 1001", busy_cnt); else n_pass++;
        n_total++; if (tmo_a !== 1'b1) $display("FAIL tmo_flag: got %b want 1", tmo_a); else n_pass++;
        n_total++; if (pass_a !== 1'b0) $display("FAIL tmo_pass: got %b want 0", pass_a); else n_pass++;
        n_total++; if (err_a !== 4'h0) $display("FAIL tmo_err: got %b want 0", err_a); else n_pass++;
    endtask

    task automatic test_stop_vs_tmo();
        bit seen;
        ch_en = 4'b0001; exp_a = 32'd0; exp_c = 16'd0; timeout_cyc = 26'd20;
        do_start();
        tick(20);
        do_stop();
        wait_done(10, seen);
        n_total++; if (!seen) $display("FAIL tie_done: got none want done pulse"); else n_pass++;
        n_total++; if (tmo_a !== 1'b0) $display("FAIL tie_tmo: got %b want 0", tmo_a); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL tie_pass: got %b want 1", pass_a); else n_pass++;
    endtask

    task automatic test_start_in_run();
        bit seen;
        ch_en = 4'b0001; exp_a = 32'd1; exp_c = 16'd1; timeout_cyc = '0;
        do_start();
        tick(2);
        pulse(4'b0001, 8, 6);
        exp_a = 32'd5; exp_c = 16'd5;
        do_start();
        n_total++; if (busy_a !== 1'b1) $display("FAIL run_start_busy: got %b want 1", busy_a); else n_pass++;
        n_total++; if (cnt_a[7:0] !== 8'd1) $display("FAIL run_start_cnt: got %0d want 1", cnt_a[7:0]); else n_pass++;
        tick(4);
        do_stop();
        wait_done(10, seen);
        n_total++; if (!seen) $display("FAIL run_start_done: got none want done pulse"); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL run_start_pass: got %b want 1", pass_a); else n_pass++;
    endtask

    task automatic test_rst_mid_run();
        bit saw;
        ch_en = 4'b0001; exp_a = 32'd0; exp_c = 16'd0;
        do_start();
        tick(2);
        pulse(4'b0001, 8, 4);
        n_total++; if (cnt_a[7:0] !== 8'd1) $display("FAIL pre_rst_cnt: got %0d want 1", cnt_a[7:0]); else n_pass++;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_total++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_a); else n_pass++;
        n_total++; if (cnt_a !== 32'h0) $display("FAIL rst_cnt: got %h want 0", cnt_a); else n_pass++;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_a === 1'b1) saw = 1'b1;
            @(negedge clk);
        end
        n_total++; if (saw !== 1'b0) $display("FAIL rst_no_done: got done want none"); else n_pass++;
    endtask

    task automatic test_saturate();
        bit seen;
        ch_en = 4'b0001; exp_a = 32'd20; exp_c = 16'h000F; timeout_cyc = '0;
        do_start();
        tick(2);
        repeat (20) pulse(4'b0011, 5, 5);
        tick(4);
        do_stop();
        wait_done(10, seen);
        n_total++; if (!seen) $display("FAIL sat_done: got none want done pulse"); else n_pass++;
        n_total++; if (cnt_c[3:0] !== 4'd15) $display("FAIL sat_cnt: got %0d want 15", cnt_c[3:0]); else n_pass++;
        n_total++; if (cnt_c[7:4] !== 4'd0) $display("FAIL sat_dis_cnt: got %0d want 0", cnt_c[7:4]); else n_pass++;
        n_total++; if (pass_c !== 1'b1) $display("FAIL sat_pass: got %b want 1", pass_c); else n_pass++;
        n_total++; if (cnt_a[7:0] !== 8'd20) $display("FAIL wide_cnt: got %0d want 20", cnt_a[7:0]); else n_pass++;
        n_total++; if (cnt_a[15:8] !== 8'd0) $display("FAIL wide_dis_cnt: got %0d want 0", cnt_a[15:8]); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL wide_pass: got %b want 1", pass_a); else n_pass++;
    endtask

    task automatic test_all_disabled();
        bit seen;
        ch_en = 4'b0000; exp_a = 32'h0505_0505; exp_c = 16'h5555; timeout_cyc = '0;
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        n_total++; if (busy_a !== 1'b1) $display("FAIL start_wins: got busy %b want 1", busy_a); else n_pass++;
        tick(3);
        do_stop();
        wait_done(10, seen);
        n_total++; if (!seen) $display("FAIL alldis_done: got none want done pulse"); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL alldis_pass: got %b want 1", pass_a); else n_pass++;
        n_total++; if (err_a !== 4'h0) $display("FAIL alldis_err: got %b want 0", err_a); else n_pass++;
        timeout_cyc = 26'd5;
        do_start();
        wait_done(20, seen);
        n_total++; if (!seen) $display("FAIL alldis_tmo_done: got none want done pulse"); else n_pass++;
        n_total++; if (pass_a !== 1'b0) $display("FAIL alldis_tmo_pass: got %b want 0", pass_a); else n_pass++;
        n_total++; if (tmo_a !== 1'b1) $display("FAIL alldis_tmo_flag: got %b want 1", tmo_a); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_exact();
        test_timeout();
        test_stop_vs_tmo();
        test_start_in_run();
        test_all_disabled();
        test_saturate();
        test_rst_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
